// File: rtl/serial_add_scheduler.sv
// Two-requester round-robin scheduler in front of a bit-serial N-bit adder.
// One addition at a time: LOAD (grant) -> N SHIFT cycles -> DONE (result pulse).
module serial_add_scheduler #(
    parameter int N = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Req0,
    input  logic [N-1:0] A0,
    input  logic [N-1:0] B0,
    input  logic         Req1,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] B1,
    output logic         Grant0,
    output logic         Grant1,
    output logic         Busy,
    output logic         Done,
    output logic         DoneId,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    localparam int CNT_W = $clog2(N + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_winner;
    logic             r_last;
    logic             r_grant0;
    logic             r_grant1;
    logic             r_done;
    logic             r_done_id;
    logic [N-1:0]     r_sum;
    logic             r_cout;

    logic             w_any_req;
    logic             w_pick;
    logic             w_sum_bit;
    logic             w_carry_nxt;
    logic [N-1:0]     w_res_nxt;
    logic             w_last_bit;

    function automatic logic f_sum_bit(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic f_majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // r_last names the requester served most recently; on a tie the other one wins.
    always_comb begin
        w_any_req = Req0 | Req1;
        w_pick    = 1'b0;
        if (Req0 && Req1) begin
            w_pick = ~r_last;
        end else if (Req1) begin
            w_pick = 1'b1;
        end
    end

    always_comb begin
        w_sum_bit   = f_sum_bit(r_a[0], r_b[0], r_carry);
        w_carry_nxt = f_majority(r_a[0], r_b[0], r_carry);
        w_res_nxt   = {w_sum_bit, r_res[N-1:1]};
        w_last_bit  = (r_cnt <= CNT_W'(1));
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_winner  <= 1'b0;
            r_last    <= 1'b1;
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
        end else begin
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_winner <= w_pick;
                        r_last   <= w_pick;
                        r_a      <= w_pick ? A1 : A0;
                        r_b      <= w_pick ? B1 : B0;
                        r_grant0 <= ~w_pick;
                        r_grant1 <= w_pick;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= CNT_W'(N);
                    r_carry <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Sum bits enter at the MSB, so after N shifts bit 0 sits at the LSB.
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_nxt;
                    r_carry <= w_carry_nxt;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (w_last_bit) begin
                        r_sum     <= w_res_nxt;
                        r_cout    <= w_carry_nxt;
                        r_done_id <= r_winner;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Grant0 = r_grant0;
    assign Grant1 = r_grant1;
    assign Busy   = (r_state != S_IDLE);
    assign Done   = r_done;
    assign DoneId = r_done_id;
    assign Sum    = r_sum;
    assign Cout   = r_cout;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Scoreboard bench for serial_add_scheduler: expected sums are queued at each grant
// from the operands the bench drove and compared when Done pulses.
module tb_serial_add_scheduler;

    localparam int N = 8;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         Req0  = 1'b0;
    logic         Req1  = 1'b0;
    logic [N-1:0] A0    = '0;
    logic [N-1:0] B0    = '0;
    logic [N-1:0] A1    = '0;
    logic [N-1:0] B1    = '0;
    logic         Grant0, Grant1, Busy, Done, DoneId, Cout;
    logic [N-1:0] Sum;

    serial_add_scheduler #(.N(N)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Req0  (Req0),
        .A0    (A0),
        .B0    (B0),
        .Req1  (Req1),
        .A1    (A1),
        .B1    (B1),
        .Grant0(Grant0),
        .Grant1(Grant1),
        .Busy  (Busy),
        .Done  (Done),
        .DoneId(DoneId),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic         id;
        logic [N-1:0] sum;
        logic         cout;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   viol  = 0;
    logic prev_g0 = 1'b0;
    logic prev_g1 = 1'b0;

    // Grants never overlap each other or Done, and each grant lasts a single cycle.
    always @(negedge Clock) begin
        if ((Grant0 && Grant1) || (Done && (Grant0 || Grant1)) ||
            (Grant0 && prev_g0) || (Grant1 && prev_g1)) begin
            viol++;
        end
        prev_g0 = Grant0;
        prev_g1 = Grant1;
    end

    function automatic exp_t model(input logic id, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t       e;
        logic [N:0] s;
        s      = {1'b0, a} + {1'b0, b};
        e.id   = id;
        e.sum  = s[N-1:0];
        e.cout = s[N];
        return e;
    endfunction

    task automatic push_exp(input logic id);
        sb.push_back(id ? model(1'b1, A1, B1) : model(1'b0, A0, B0));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_grant(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (Grant0 || Grant1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (Done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        tests++;
        if ({Grant0, Grant1, Busy, Done, DoneId, Sum, Cout} !== '0) begin
            fails++;
            $display("FAIL reset_state: got g0=%b g1=%b busy=%b done=%b id=%b sum=%h cout=%b, need all 0",
                     Grant0, Grant1, Busy, Done, DoneId, Sum, Cout);
        end
        Reset = 1'b1;
        tick();
        tests++;
        if (Busy !== 1'b0 || Grant0 !== 1'b0 || Grant1 !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_req: busy=%b g0=%b g1=%b, need 0 0 0", Busy, Grant0, Grant1);
        end
    endtask

    task automatic test_single0();
        int   c, d;
        exp_t e;
        A0 = 8'h35; B0 = 8'h4A; Req0 = 1'b1;
        wait_grant(4, c);
        tests++;
        if (c != 1 || Grant0 !== 1'b1 || Grant1 !== 1'b0 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL single0_grant: cyc=%0d g0=%b g1=%b busy=%b, need 1 1 0 1", c, Grant0, Grant1, Busy);
        end
        if (c > 0) push_exp(Grant1);
        Req0 = 1'b0;
        wait_done(20, d);
        tests++;
        if (d != N + 1) begin
            fails++;
            $display("FAIL single0_latency: got %0d cycles, need %0d", d, N + 1);
        end
        tests++;
        if (d < 0 || sb.size() == 0) begin
            fails++;
            $display("FAIL single0_result: no Done seen (got none, need one)");
        end else begin
            e = sb.pop_front();
            if ({DoneId, Sum, Cout} !== {e.id, e.sum, e.cout} || Busy !== 1'b1) begin
                fails++;
                $display("FAIL single0_result: got id=%b sum=%h cout=%b busy=%b, need id=%b sum=%h cout=%b busy=1",
                         DoneId, Sum, Cout, Busy, e.id, e.sum, e.cout);
            end
        end
        tick();
        tests++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Sum !== 8'h7F || Cout !== 1'b0) begin
            fails++;
            $display("FAIL single0_hold: busy=%b done=%b sum=%h cout=%b, need 0 0 7f 0", Busy, Done, Sum, Cout);
        end
    endtask

    task automatic test_single1();
        int           c, d;
        exp_t         e;
        logic [N-1:0] ta[2];
        logic [N-1:0] tb[2];
        ta[0] = 8'hFF; tb[0] = 8'h01;
        ta[1] = 8'h80; tb[1] = 8'h80;
        for (int k = 0; k < 2; k++) begin
            A1 = ta[k]; B1 = tb[k]; Req1 = 1'b1;
            wait_grant(6, c);
            tests++;
            if (c < 0 || Grant1 !== 1'b1 || Grant0 !== 1'b0) begin
                fails++;
                $display("FAIL single1_grant%0d: cyc=%0d g0=%b g1=%b, need g1 only", k, c, Grant0, Grant1);
            end
            if (c > 0) push_exp(Grant1);
            Req1 = 1'b0;
            wait_done(20, d);
            tests++;
            if (d < 0 || sb.size() == 0) begin
                fails++;
                $display("FAIL single1_result%0d: no Done seen", k);
            end else begin
                e = sb.pop_front();
                if ({DoneId, Sum, Cout} !== {e.id, e.sum, e.cout}) begin
                    fails++;
                    $display("FAIL single1_result%0d: got id=%b sum=%h cout=%b, need id=%b sum=%h cout=%b",
                             k, DoneId, Sum, Cout, e.id, e.sum, e.cout);
                end
            end
        end
    endtask

    task automatic test_both();
        int   c, c2, d;
        exp_t e;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        A0 = 8'h10; B0 = 8'h20; A1 = 8'h0F; B1 = 8'h01;
        Req0 = 1'b1; Req1 = 1'b1;
        wait_grant(4, c);
        tests++;
        if (c < 0 || Grant0 !== 1'b1) begin
            fails++;
            $display("FAIL both_first: cyc=%0d g0=%b g1=%b, need g0 first", c, Grant0, Grant1);
        end
        if (c > 0) push_exp(Grant1);
        Req0 = 1'b0;
        wait_done(20, d);
        tests++;
        if (d < 0 || sb.size() == 0) begin
            fails++;
            $display("FAIL both_result0: no Done seen");
        end else begin
            e = sb.pop_front();
            if ({DoneId, Sum, Cout} !== {e.id, e.sum, e.cout}) begin
                fails++;
                $display("FAIL both_result0: got id=%b sum=%h, need id=%b sum=%h", DoneId, Sum, e.id, e.sum);
            end
        end
        wait_grant(6, c2);
        tests++;
        if (c2 < 0 || Grant1 !== 1'b1 || d + c2 != 11) begin
            fails++;
            $display("FAIL both_second: g1=%b spacing=%0d, need g1=1 spacing=11", Grant1, d + c2);
        end
        if (c2 > 0) push_exp(Grant1);
        Req1 = 1'b0;
        wait_done(20, d);
        tests++;
        if (d < 0 || sb.size() == 0) begin
            fails++;
            $display("FAIL both_result1: no Done seen");
        end else begin
            e = sb.pop_front();
            if ({DoneId, Sum, Cout} !== {e.id, e.sum, e.cout}) begin
                fails++;
                $display("FAIL both_result1: got id=%b sum=%h, need id=%b sum=%h", DoneId, Sum, e.id, e.sum);
            end
        end
    endtask

    task automatic test_alternate();
        int   c, d;
        exp_t e;
        A0 = 8'h5C; B0 = 8'h21; A1 = 8'hF0; B1 = 8'h20;
        Req0 = 1'b1; Req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(14, c);
            tests++;
            if (c < 0 || Grant1 !== k[0] || Grant0 !== ~k[0]) begin
                fails++;
                $display("FAIL alt_grant%0d: g0=%b g1=%b, need g1=%b", k, Grant0, Grant1, k[0]);
            end
            if (c > 0) push_exp(Grant1);
            if (k == 3) begin
                Req0 = 1'b0;
                Req1 = 1'b0;
            end
            wait_done(20, d);
            tests++;
            if (d < 0 || sb.size() == 0) begin
                fails++;
                $display("FAIL alt_result%0d: no Done seen", k);
            end else begin
                e = sb.pop_front();
                if ({DoneId, Sum, Cout} !== {e.id, e.sum, e.cout}) begin
                    fails++;
                    $display("FAIL alt_result%0d: got id=%b sum=%h cout=%b, need id=%b sum=%h cout=%b",
                             k, DoneId, Sum, Cout, e.id, e.sum, e.cout);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int   c, d;
        exp_t e;
        A0 = 8'hC3; B0 = 8'h5A; Req0 = 1'b1;
        wait_grant(4, c);
        tests++;
        if (c < 0 || Grant0 !== 1'b1) begin
            fails++;
            $display("FAIL rmid_grant: g0=%b, need 1", Grant0);
        end
        tick(); tick(); tick();
        Reset = 1'b0;
        tick();
        tests++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Sum !== '0 || Cout !== 1'b0) begin
            fails++;
            $display("FAIL rmid_abort: busy=%b done=%b sum=%h cout=%b, need 0 0 00 0", Busy, Done, Sum, Cout);
        end
        Reset = 1'b1;
        wait_grant(4, c);
        tests++;
        if (c != 1 || Grant0 !== 1'b1) begin
            fails++;
            $display("FAIL rmid_regrant: cyc=%0d g0=%b, need 1 1", c, Grant0);
        end
        if (c > 0) push_exp(Grant1);
        Req0 = 1'b0;
        wait_done(20, d);
        tests++;
        if (d != N + 1 || sb.size() == 0) begin
            fails++;
            $display("FAIL rmid_result: done after %0d cycles, need %0d", d, N + 1);
        end else begin
            e = sb.pop_front();
            if ({DoneId, Sum, Cout} !== {e.id, e.sum, e.cout}) begin
                fails++;
                $display("FAIL rmid_result: got id=%b sum=%h cout=%b, need id=%b sum=%h cout=%b",
                         DoneId, Sum, Cout, e.id, e.sum, e.cout);
            end
        end
    endtask

    task automatic test_busy_req();
        int   c, d;
        exp_t e;
        A0 = 8'h11; B0 = 8'h22; Req0 = 1'b1;
        wait_grant(4, c);
        if (c > 0) push_exp(Grant1);
        Req0 = 1'b0;
        tick(); tick();
        A1 = 8'h33; B1 = 8'h44; Req1 = 1'b1;
        wait_done(20, d);
        tests++;
        if (d != N - 1 || sb.size() == 0 || DoneId !== 1'b0) begin
            fails++;
            $display("FAIL busy_done0: cyc=%0d id=%b, need %0d id=0", d, DoneId, N - 1);
        end else begin
            e = sb.pop_front();
            if (Sum !== e.sum) begin
                fails++;
                $display("FAIL busy_done0: got sum=%h, need %h", Sum, e.sum);
            end
        end
        wait_grant(6, c);
        tests++;
        if (c != 2 || Grant1 !== 1'b1) begin
            fails++;
            $display("FAIL busy_grant1: cyc after Done=%0d g1=%b, need 2 1", c, Grant1);
        end
        if (c > 0) push_exp(Grant1);
        Req1 = 1'b0;
        wait_done(20, d);
        tests++;
        if (d < 0 || sb.size() == 0) begin
            fails++;
            $display("FAIL busy_result1: no Done seen");
        end else begin
            e = sb.pop_front();
            if ({DoneId, Sum, Cout} !== {e.id, e.sum, e.cout}) begin
                fails++;
                $display("FAIL busy_result1: got id=%b sum=%h, need id=%b sum=%h", DoneId, Sum, e.id, e.sum);
            end
        end
    endtask

    task automatic test_drop();
        int   c, d;
        exp_t e;
        A0 = 8'h7E; B0 = 8'h03; Req0 = 1'b1;
        wait_grant(4, c);
        if (c > 0) push_exp(Grant1);
        Req0 = 1'b0;
        tick(); tick();
        Req1 = 1'b1;
        tick(); tick();
        Req1 = 1'b0;
        wait_done(20, d);
        tests++;
        if (d < 0 || sb.size() == 0) begin
            fails++;
            $display("FAIL drop_result: no Done seen");
        end else begin
            e = sb.pop_front();
            if ({DoneId, Sum, Cout} !== {e.id, e.sum, e.cout}) begin
                fails++;
                $display("FAIL drop_result: got sum=%h, need %h", Sum, e.sum);
            end
        end
        wait_grant(12, c);
        tests++;
        if (c != -1) begin
            fails++;
            $display("FAIL drop_nogrant: grant seen after %0d cycles, need none", c);
        end
    endtask

    task automatic test_back_to_back();
        int   c, d;
        exp_t e;
        A0 = 8'(($urandom_range(0, 255))); B0 = 8'(($urandom_range(0, 255)));
        Req0 = 1'b1;
        wait_grant(4, c);
        if (c > 0) push_exp(Grant1);
        for (int k = 0; k < 2; k++) begin
            wait_done(20, d);
            tests++;
            if (d != N + 1 || sb.size() == 0) begin
                fails++;
                $display("FAIL b2b_done%0d: cyc=%0d, need %0d", k, d, N + 1);
            end else begin
                e = sb.pop_front();
                if ({DoneId, Sum, Cout} !== {e.id, e.sum, e.cout}) begin
                    fails++;
                    $display("FAIL b2b_result%0d: got sum=%h cout=%b, need sum=%h cout=%b",
                             k, Sum, Cout, e.sum, e.cout);
                end
            end
            if (k == 0) begin
                wait_grant(6, c);
                tests++;
                if (c != 2 || Grant0 !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_period: spacing=%0d g0=%b, need %0d 1", d + c, Grant0, N + 3);
                end
                if (c > 0) push_exp(Grant1);
                Req0 = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        int   c, d;
        exp_t e;
        logic side;
        for (int k = 0; k < 6; k++) begin
            side = 1'($urandom_range(0, 1));
            A0 = 8'($urandom_range(0, 255)); B0 = 8'($urandom_range(0, 255));
            A1 = 8'($urandom_range(0, 255)); B1 = 8'($urandom_range(0, 255));
            Req0 = ~side; Req1 = side;
            wait_grant(6, c);
            if (c > 0) push_exp(Grant1);
            Req0 = 1'b0; Req1 = 1'b0;
            wait_done(20, d);
            tests++;
            if (d < 0 || sb.size() == 0) begin
                fails++;
                $display("FAIL rand%0d: no Done seen", k);
            end else begin
                e = sb.pop_front();
                if ({DoneId, Sum, Cout} !== {side, e.sum, e.cout} || e.id !== side) begin
                    fails++;
                    $display("FAIL rand%0d: got id=%b sum=%h cout=%b, need id=%b sum=%h cout=%b",
                             k, DoneId, Sum, Cout, side, e.sum, e.cout);
                end
            end
        end
    endtask

    task automatic test_exclusive();
        tests++;
        if (viol !== 0) begin
            fails++;
            $display("FAIL grant_exclusive: %0d overlapping/long pulse cycles, need 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single0();
        test_single1();
        test_both();
        test_alternate();
        test_reset_mid();
        test_busy_req();
        test_drop();
        test_back_to_back();
        test_random();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
